motor_ctrl_axil_regs: RTL

AXI4-Lite slave register file, the responder side of the S00_AXI port that the bench master drives. It holds four read/write control words (CTRL, DUTY, PERIOD, AUX) at 0x00-0x0C and one read-only STATUS word at 0x10, and drives them to the motor datapath. It sits between the AXI interconnect/VIP master and the PWM/motor core.

---
 rtl/motor_ctrl_axil_regs_pkg.sv | 17 +
 rtl/motor_ctrl_axil_regs.sv | 96 +++++++++
 2 files changed

// File: rtl/motor_ctrl_axil_regs_pkg.sv
// motor_ctrl_pkg: register indices, response codes and FSM states for the motor control register file
package motor_ctrl_pkg;
  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_DUTY = 3'd1;
  localparam logic [2:0] REG_PERIOD = 3'd2;
  localparam logic [2:0] REG_AUX = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val, input logic [31:0] new_val, input logic [3:0] strb);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) res[8*k +: 8] = strb[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
    return res;
  endfunction
endpackage

// File: rtl/motor_ctrl_axil_regs.sv
// motor_ctrl_axil_regs: AXI4-Lite slave holding four R/W motor control words and a live STATUS word
module motor_ctrl_axil_regs
  import motor_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_RESET_VAL = 32'h0
) (
  input  logic s_axi_aclk,
  input  logic s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0] s_axi_awprot,
  input  logic s_axi_awvalid,
  output logic s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic s_axi_wvalid,
  output logic s_axi_wready,
  output logic [1:0] s_axi_bresp,
  output logic s_axi_bvalid,
  input  logic s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0] s_axi_arprot,
  input  logic s_axi_arvalid,
  output logic s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0] s_axi_rresp,
  output logic s_axi_rvalid,
  input  logic s_axi_rready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [3:0] reg_wr_pulse
);
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic [2:0] aw_idx_q, wr_idx, rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wr_data, rd_val;
  logic [3:0] wstrb_q, wr_strb;
  logic aw_hs, w_hs, ar_hs, commit;
  logic unused;
  assign unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  // readies are gated by reset so nothing is accepted while held in reset
  assign s_axi_awready = s_axi_aresetn && (w_state == W_IDLE || w_state == W_HAVE_W);
  assign s_axi_wready = s_axi_aresetn && (w_state == W_IDLE || w_state == W_HAVE_AW);
  assign s_axi_arready = s_axi_aresetn && r_state == R_IDLE;
  assign s_axi_bvalid = w_state == W_RESP;
  assign s_axi_rvalid = r_state == R_DATA;
  assign s_axi_rresp = RESP_OKAY;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign wr_idx = w_state == W_HAVE_AW ? aw_idx_q : s_axi_awaddr[4:2];
  assign wr_data = w_state == W_HAVE_W ? wdata_q : s_axi_wdata;
  assign wr_strb = w_state == W_HAVE_W ? wstrb_q : s_axi_wstrb;
  assign commit = w_state != W_RESP && w_next == W_RESP;
  assign rd_idx = s_axi_araddr[4:2];
  assign rd_val = !rd_idx[2] ? regs[rd_idx[1:0]] : rd_idx == REG_STATUS ? status_in : '0;
  assign reg_out = {regs[3], regs[2], regs[1], regs[0]};
  always_comb begin
    w_next = w_state == W_RESP ? (s_axi_bready ? W_IDLE : W_RESP)
           : (aw_hs || w_state == W_HAVE_AW) && (w_hs || w_state == W_HAVE_W) ? W_RESP
           : aw_hs ? W_HAVE_AW : w_hs ? W_HAVE_W : w_state;
    r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (s_axi_rready ? R_IDLE : R_DATA);
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      regs <= '{default: C_RESET_VAL};
      aw_idx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      s_axi_bresp <= RESP_OKAY;
      s_axi_rdata <= '0;
      reg_wr_pulse <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= s_axi_awaddr[4:2];
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      reg_wr_pulse <= commit && !wr_idx[2] ? 4'b0001 << wr_idx[1:0] : 4'b0000;
      if (commit) begin
        s_axi_bresp <= wr_idx[2] ? RESP_SLVERR : RESP_OKAY;
        if (!wr_idx[2]) regs[wr_idx[1:0]] <= merge_bytes(regs[wr_idx[1:0]], wr_data, wr_strb);
      end
      if (ar_hs) s_axi_rdata <= rd_val;
    end
endmodule
